// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard deframer: filters ps2_clk, checks odd parity/stop, resolves E0/F0 prefixes into key events.
// Latency: key_en/frame_err 1 iCLK after the stop-bit sample (sample = filtered clk fall, ~FILTER_LEN+2 after raw fall).
// No backpressure: events are one-cycle strobes. `TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_en,
  output logic       key_ext,
  output logic       key_break,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FCNT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] timer;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic          ext_flg, brk_flg;

  logic sample, timer_hit, start_err, tmo, byte_done, byte_ok;
  logic is_e0, is_f0, key_byte, suppress, key_fire, err_fire;

  // Sample strobe marks the cycle the filtered clock is about to fall
  assign sample    = clk_filt && !clk_s2 && (fcnt == FCNT_MAX);
  assign timer_hit = (timer == TMR_MAX);
  assign is_e0     = (shreg == 8'hE0);
  assign is_f0     = (shreg == 8'hF0);
  assign key_byte  = byte_ok && !is_e0 && !is_f0;

`ifdef TYPEMATIC_FILTER_EN
  logic       held_vld, held_ext;
  logic [7:0] held_code;
  logic       held_match;
  assign held_match = held_vld && (held_code == shreg) && (held_ext == ext_flg);
  assign suppress   = !brk_flg && held_match;
`else
  assign suppress   = 1'b0;
`endif

  assign key_fire = key_byte && !suppress;
  assign err_fire = start_err || tmo || (byte_done && !byte_ok);

  always_comb begin
    state_nxt = state;
    start_err = 1'b0;
    tmo       = 1'b0;
    byte_done = 1'b0;
    byte_ok   = 1'b0;
    if (sample) begin
      case (state)
        S_IDLE: begin
          if (!dat_s2) state_nxt = S_DATA;
          else         start_err = 1'b1;
        end
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          byte_done = 1'b1;
          byte_ok   = dat_s2 && (^{shreg, par_bit});
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && timer_hit) begin
      state_nxt = S_IDLE;
      tmo       = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (clk_s2 != clk_filt) begin
        if (fcnt == FCNT_MAX) begin
          clk_filt <= clk_s2;
          fcnt     <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      timer     <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      ext_flg   <= 1'b0;
      brk_flg   <= 1'b0;
      key_code  <= '0;
      key_en    <= 1'b0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_en    <= key_fire;
      frame_err <= err_fire;

      if (state == S_IDLE || sample) timer <= '0;
      else if (!timer_hit)           timer <= timer + 1'b1;

      if (sample) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: par_bit <= dat_s2;
          default: ;
        endcase
      end

      if (err_fire) begin
        ext_flg <= 1'b0;
        brk_flg <= 1'b0;
      end else if (byte_ok) begin
        if (is_e0) ext_flg <= 1'b1;
        else if (is_f0) brk_flg <= 1'b1;
        else begin
          ext_flg <= 1'b0;
          brk_flg <= 1'b0;
        end
      end

      if (key_fire) begin
        key_code  <= shreg;
        key_ext   <= ext_flg;
        key_break <= brk_flg;
      end
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      held_vld  <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
    end else if (key_byte) begin
      if (!brk_flg && !held_match) begin
        held_vld  <= 1'b1;
        held_ext  <= ext_flg;
        held_code <= shreg;
      end else if (brk_flg && held_match) begin
        held_vld <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomised PS/2 frame stimulus checked against a byte-level decoder model with exact latency.
module tb_ps2_scan_decoder;
  localparam int FL = 4;
  localparam int TO = 2000;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       ps2_clk, ps2_data;
  logic [7:0] key_code;
  logic       key_en, key_ext, key_break, frame_err;

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .iCLK(iCLK), .iRST(iRST), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_en(key_en), .key_ext(key_ext),
    .key_break(key_break), .frame_err(frame_err)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_key = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       ext, brk, err;
    int         t;
  } ev_t;
  ev_t evq[$];
  bit  prev_strobe = 1'b0;

  always @(negedge iCLK) begin
    if (!iRST) begin
      if (key_en || frame_err) begin
        ev_t e;
        check("excl", {31'd0, key_en & frame_err}, 0);
        check("consec", {31'd0, prev_strobe}, 0);
        e.code = key_code; e.ext = key_ext; e.brk = key_break; e.err = frame_err; e.t = cyc;
        evq.push_back(e);
        if (key_en) n_key++;
      end
      prev_strobe = key_en | frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // reference decoder state
  bit       m_ext, m_brk, m_hv, m_he;
  bit [7:0] m_hc;

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int nbits, input int hp,
                          input bit glitch, output int last_fall);
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(hp / 2);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0; tick(FL - 1); ps2_clk = 1'b1;
        tick(hp - hp / 2 - (FL - 1));
      end else begin
        tick(hp - hp / 2);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      tick(hp);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic expect_frame(input bit want, input bit want_err, input logic [7:0] code,
                              input bit ext, input bit brk, input int t);
    if (!want) begin
      check("no_event", evq.size(), 0);
    end else begin
      check("event_cnt", evq.size(), 1);
      if (evq.size() > 0) begin
        ev_t e;
        e = evq.pop_front();
        check("err_flag", {31'd0, e.err}, {31'd0, want_err});
        if (!want_err) begin
          check("key_code", {24'd0, e.code}, {24'd0, code});
          check("key_ext", {31'd0, e.ext}, {31'd0, ext});
          check("key_break", {31'd0, e.brk}, {31'd0, brk});
        end
        check("latency", e.t, t);
      end
    end
    evq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit glitch, input int hp);
    logic [10:0] bits;
    int          k;
    bit          good, emit;
    logic [7:0]  exp_code;
    bit          exp_ext, exp_brk;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    ps2_bits(bits, 11, hp, glitch, k);
    good = !bad_par && !bad_stop;
    emit = 1'b0;
    exp_code = b; exp_ext = m_ext; exp_brk = m_brk;
    if (!good) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      emit = 1'b1;
`ifdef TYPEMATIC_FILTER_EN
      if (!m_brk) begin
        if (m_hv && m_hc == b && m_he == m_ext) emit = 1'b0;
        else begin m_hv = 1; m_hc = b; m_he = m_ext; end
      end else if (m_hv && m_hc == b && m_he == m_ext) begin
        m_hv = 0;
      end
`endif
      m_ext = 0; m_brk = 0;
    end
    expect_frame(!good || emit, !good, exp_code, exp_ext, exp_brk, k + FL + 2);
    tick(hp);
  endtask

  initial begin
    int k0, keys0;
    logic [7:0] pool [7];
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C};
    m_ext = 0; m_brk = 0; m_hv = 0; m_he = 0; m_hc = 0;

    iRST = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    iRST = 1'b0;
    tick(2);
    check("rst_key_en", {31'd0, key_en}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_key_code", {24'd0, key_code}, 0);
    check("rst_ext_brk", {30'd0, key_ext, key_break}, 0);

    // extended make, then extended break
    send_byte(8'hE0, 0, 0, 0, 20);
    send_byte(8'h75, 0, 0, 0, 20);
    send_byte(8'hE0, 0, 0, 0, 20);
    send_byte(8'hF0, 0, 0, 0, 20);
    send_byte(8'h6B, 0, 0, 0, 20);
    send_byte(8'h72, 0, 0, 0, 20);

    // parity and stop errors
    send_byte(8'h74, 1, 0, 0, 20);
    send_byte(8'h74, 0, 0, 0, 20);
    send_byte(8'hE0, 0, 0, 0, 20);
    send_byte(8'h74, 0, 1, 0, 20);
    send_byte(8'h74, 0, 0, 0, 20);

    // timeout after start + 5 data bits
    send_byte(8'hE0, 0, 0, 0, 20);
    ps2_bits({3'b111, 8'h72}, 6, 20, 0, k0);
    tick(TO + 20);
    expect_frame(1, 1, 8'h00, 0, 0, k0 + FL + 2 + TO);
    m_ext = 0; m_brk = 0;
    send_byte(8'h72, 0, 0, 0, 20);

    // short clock glitch mid-frame
    send_byte(8'h6B, 0, 0, 1, 20);

    // reset mid-frame
    ps2_bits({3'b111, 8'h1C}, 4, 20, 0, k0);
    iRST = 1'b1; tick(2); iRST = 1'b0;
    m_ext = 0; m_brk = 0; m_hv = 0;
    tick(60);
    expect_frame(0, 0, 8'h00, 0, 0, 0);
    send_byte(8'h1C, 0, 0, 0, 20);

    // typematic repeats
    keys0 = n_key;
    for (int r = 0; r < 3; r++) begin
      send_byte(8'hE0, 0, 0, 0, 16);
      send_byte(8'h75, 0, 0, 0, 16);
    end
    send_byte(8'hE0, 0, 0, 0, 16);
    send_byte(8'hF0, 0, 0, 0, 16);
    send_byte(8'h75, 0, 0, 0, 16);
`ifdef TYPEMATIC_FILTER_EN
    check("typematic_cnt", n_key - keys0, 2);
`else
    check("typematic_cnt", n_key - keys0, 4);
`endif

    // random frames
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      send_byte(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(12, 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
